// File: rtl/risc_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction/status inputs, datapath strobes and status outputs.
// The sequencer side uses the master modport; the datapath (or bench) uses slave.
interface risc_sequencer_if #(
    parameter int unsigned OPCODE_W = 3,
    parameter int unsigned COUNT_W  = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                neg;
    logic                mem_ready;
    logic                resume;

    logic                sel;
    logic                rd;
    logic                ld_ir;
    logic                inc_pc;
    logic                halt;
    logic                ld_pc;
    logic                data_e;
    logic                ld_ac;
    logic                wr;

    logic [2:0]          phase;
    logic                halted;
    logic                illegal;
    logic [COUNT_W-1:0]  retired;

    modport master (
        input  opcode, zero, neg, mem_ready, resume,
        output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr,
        output phase, halted, illegal, retired
    );

    modport slave (
        output opcode, zero, neg, mem_ready, resume,
        input  sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr,
        input  phase, halted, illegal, retired
    );
endinterface

// File: rtl/risc_sequencer.sv
// Eight-phase instruction sequencer: decodes per-phase datapath strobes, handles memory
// stalls, halt/resume, a sticky illegal-opcode flag and a retired-instruction counter.
module risc_sequencer #(
    parameter int unsigned OPCODE_W = 3,
    parameter int unsigned COUNT_W  = 16,
    parameter int unsigned STALL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    risc_sequencer_if.master bus
);
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned OP_W    = 4;
    localparam bit          STALL_ON = (STALL_EN != 0);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic                 illegal_q, illegal_d;
    logic [COUNT_W-1:0]   retired_q, retired_d;

    logic [OPCODE_W-1:0]  opc;
    logic [OP_W-1:0]      op;
    logic                 is_ill, cls_h, cls_a, cls_z, cls_j, cls_s;
    logic                 sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
    logic                 stall;

    // Opcode classes; a 3-bit opcode zero-extends, so codes 8..15 never occur there.
    always_comb begin
        opc    = bus.opcode;
        op     = OP_W'(opc);
        is_ill = (op >= OP_W'(12));
        cls_h  = (op == OP_W'(0)) || is_ill;
        cls_a  = (op inside {OP_W'(2), OP_W'(3), OP_W'(4), OP_W'(5), OP_W'(8), OP_W'(9)});
        cls_z  = ((op == OP_W'(1)) && bus.zero) || ((op == OP_W'(10)) && bus.neg);
        cls_j  = (op == OP_W'(7));
        cls_s  = (op == OP_W'(6));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            phase_q   <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Strobe decode and next-state; strobes depend only on state, phase and opcode/flags.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        sel = 1'b0; rd = 1'b0; ld_ir = 1'b0; inc_pc = 1'b0; halt = 1'b0;
        ld_pc = 1'b0; data_e = 1'b0; ld_ac = 1'b0; wr = 1'b0;
        stall = 1'b0;

        if (state_q == ST_HALT) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                3'd0: sel = 1'b1;
                3'd1: begin sel = 1'b1; rd = 1'b1; end
                3'd2: begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
                3'd3: begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
                3'd4: begin inc_pc = 1'b1; halt = cls_h; end
                3'd5: rd = cls_a;
                3'd6: begin rd = cls_a; inc_pc = cls_z; ld_pc = cls_j; data_e = cls_s; end
                3'd7: begin
                    rd = cls_a; ld_pc = cls_j; data_e = cls_s; ld_ac = cls_a; wr = cls_s;
                end
            endcase
        end

        stall = STALL_ON && (state_q == ST_RUN) && !bus.mem_ready &&
                ((phase_q == 3'd3) || ((phase_q == 3'd7) && (rd || wr)));

        unique case (state_q)
            ST_HALT: begin
                phase_d = '0;
                if (bus.resume) state_d = ST_RUN;
            end
            ST_RUN: begin
                if ((phase_q == 3'd4) && cls_h) begin
                    state_d = ST_HALT;
                    phase_d = '0;
                    if (is_ill) illegal_d = 1'b1;
                end else if (!stall) begin
                    phase_d = phase_q + 3'd1;
                    if (phase_q == 3'd7) retired_d = retired_q + COUNT_W'(1);
                end
            end
        endcase
    end

    assign bus.sel     = sel;
    assign bus.rd      = rd;
    assign bus.ld_ir   = ld_ir;
    assign bus.inc_pc  = inc_pc;
    assign bus.halt    = halt;
    assign bus.ld_pc   = ld_pc;
    assign bus.data_e  = data_e;
    assign bus.ld_ac   = ld_ac;
    assign bus.wr      = wr;
    assign bus.phase   = phase_q;
    assign bus.halted  = (state_q == ST_HALT);
    assign bus.illegal = illegal_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_risc_sequencer.sv
// Self-checking bench for risc_sequencer (OPCODE_W=4, small counter to exercise wrap):
// directed scenarios followed by randomized cycles, all checked against a behavioural model.
module tb_risc_sequencer;
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned COUNT_W  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    risc_sequencer_if #(.OPCODE_W(OPCODE_W), .COUNT_W(COUNT_W)) bus ();

    risc_sequencer #(.OPCODE_W(OPCODE_W), .COUNT_W(COUNT_W), .STALL_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int m_phase;
    bit m_halted;
    bit m_ill;
    int m_ret;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic bit is_alu(input int op);
        return (op >= 2 && op <= 5) || op == 8 || op == 9;
    endfunction

    function automatic bit is_hlt(input int op);
        return op == 0 || op >= 12;
    endfunction

    // Expected strobes {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr} from the phase table.
    function automatic logic [8:0] exp_strobes();
        int op = int'(bus.opcode);
        bit run = !m_halted;
        bit a = is_alu(op);
        bit j = (op == 7);
        bit s = (op == 6);
        bit z = (op == 1 && bus.zero) || (op == 10 && bus.neg);
        bit late = (m_phase == 6 || m_phase == 7);
        logic [8:0] v;
        v[8] = run && m_phase <= 3;
        v[7] = run && ((m_phase >= 1 && m_phase <= 3) || (m_phase >= 5 && a));
        v[6] = run && (m_phase == 2 || m_phase == 3);
        v[5] = run && (m_phase == 4 || (m_phase == 6 && z));
        v[4] = m_halted || (m_phase == 4 && is_hlt(op));
        v[3] = run && late && j;
        v[2] = run && late && s;
        v[1] = run && m_phase == 7 && a;
        v[0] = run && m_phase == 7 && s;
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_halted = 0; m_ill = 0; m_ret = 0;
    endtask

    // Advance the model by one clock edge using the inputs presented at that edge.
    task automatic model_edge();
        int op = int'(bus.opcode);
        bit waits;
        if (m_halted) begin
            if (bus.resume) m_halted = 0;
            m_phase = 0;
        end else if (m_phase == 4 && is_hlt(op)) begin
            m_halted = 1;
            m_phase  = 0;
            if (op >= 12) m_ill = 1;
        end else begin
            waits = !bus.mem_ready &&
                    (m_phase == 3 || (m_phase == 7 && (is_alu(op) || op == 6)));
            if (!waits) begin
                if (m_phase == 7) m_ret = (m_ret + 1) % (1 << COUNT_W);
                m_phase = (m_phase + 1) % 8;
            end
        end
    endtask

    task automatic check_all();
        check("phase",   32'(bus.phase),   32'(m_phase));
        check("halted",  32'(bus.halted),  32'(m_halted));
        check("illegal", 32'(bus.illegal), 32'(m_ill));
        check("retired", 32'(bus.retired), 32'(m_ret));
        check("strobes", 32'({bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.halt,
                              bus.ld_pc, bus.data_e, bus.ld_ac, bus.wr}),
              32'(exp_strobes()));
    endtask

    // Present inputs, check the cycle, then take one clock edge.
    task automatic cyc(input int op, input bit z, input bit n, input bit mr, input bit rs);
        bus.opcode = OPCODE_W'(op);
        bus.zero = z; bus.neg = n; bus.mem_ready = mr; bus.resume = rs;
        #2;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_instr(input int op, input bit z, input bit n);
        for (int i = 0; i < 8; i++) cyc(op, z, n, 1'b1, 1'b0);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("rst_sel", 32'(bus.sel), 32'd1);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int op;
        rst = 1'b1;
        bus.opcode = '0; bus.zero = 0; bus.neg = 0; bus.mem_ready = 0; bus.resume = 0;
        model_reset();
        #3;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // ADD: eight phases, one retirement
        run_instr(2, 0, 0);
        check("add_retired", 32'(bus.retired), 32'd1);

        // STO with memory not ready for three cycles in phase 7
        for (int i = 0; i < 7; i++) cyc(6, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(6, 0, 0, 1'b0, 1'b0);
            check("sto_hold", 32'({bus.phase, bus.wr, bus.data_e}), 32'({3'd7, 1'b1, 1'b1}));
        end
        cyc(6, 0, 0, 1'b1, 1'b0);
        check("sto_retired", 32'(bus.retired), 32'd2);

        // SKZ taken / not taken, and SKN taken
        run_instr(1, 1, 0);
        run_instr(1, 0, 0);
        run_instr(10, 0, 1);

        // HLT: halt for 10 clocks ignoring mem_ready, then resume
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1'($urandom_range(0, 1)), 1'b0);
        check("hlt_state", 32'({bus.halted, bus.phase}), 32'({1'b1, 3'd0}));
        cyc(0, 0, 0, 1'b1, 1'b1);
        check("resume_clr", 32'(bus.halted), 32'd0);
        cyc(2, 0, 0, 1'b1, 1'b0);
        check("resume_ph1", 32'(bus.phase), 32'd1);
        check("hlt_retired", 32'(bus.retired), 32'd5);
        for (int i = 0; i < 7; i++) cyc(2, 0, 0, 1'b1, 1'b0);

        // Illegal opcode 13, with resume on the halting edge (must be ignored)
        for (int i = 0; i < 4; i++) cyc(13, 0, 0, 1'b1, 1'b0);
        cyc(13, 0, 0, 1'b1, 1'b1);
        check("ill_set", 32'({bus.halted, bus.illegal}), 32'({1'b1, 1'b1}));
        cyc(13, 0, 0, 1'b1, 1'b1);
        run_instr(3, 0, 0);
        check("ill_sticky", 32'({bus.halted, bus.illegal}), 32'({1'b0, 1'b1}));

        // Reset in phase 5 of LDA
        for (int i = 0; i < 5; i++) cyc(5, 0, 0, 1'b1, 1'b0);
        mid_reset();
        check("rst_retired", 32'(bus.retired), 32'd0);
        cyc(5, 0, 0, 1'b1, 1'b0);
        check("rst_adv", 32'(bus.phase), 32'd1);

        // Randomized traffic with rare asynchronous resets
        for (int c = 0; c < 2000; c++) begin
            op = int'($urandom_range(0, 15));
            if ((op == 0 || op >= 12) && $urandom_range(0, 3) != 0)
                op = int'($urandom_range(1, 11));
            cyc(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) mid_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
